// File: rtl/mmu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmu_pkg : shared constants and types for the mmu_paged 6809 MMU           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mmu_pkg;

  // Control register offsets within the 8-byte register block
  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_AKEY  = 3'd1;
  localparam logic [2:0] REG_TKEY  = 3'd2;
  localparam logic [2:0] REG_RTI   = 3'd3;
  localparam logic [2:0] REG_WAITS = 3'd4;
  localparam logic [2:0] REG_FSTAT = 3'd5;

  localparam int CTRL_ENMMU = 0;
  localparam int CTRL_FIE   = 1;
  localparam int CTRL_NU    = 2;

  localparam logic [7:0] RTI_OPCODE = 8'h3B;

  // Entry byte layout: WP and SLOW sit above the widest allowed frame field
  localparam int MAX_FRAME_W    = 6;
  localparam int ENTRY_SLOW_BIT = MAX_FRAME_W;
  localparam int ENTRY_WP_BIT   = MAX_FRAME_W + 1;

  // Encoding is {QX, EX}
  typedef enum logic [1:0] {
    CK_00 = 2'b00,
    CK_10 = 2'b10,
    CK_11 = 2'b11,
    CK_01 = 2'b01
  } ck_state_t;

endpackage : mmu_pkg
`default_nettype wire

// File: rtl/mmu_clkgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmu_clkgen : Q/E generator with wait stretching; emits the commit pulse   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mmu_clkgen
  import mmu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mrdy,
  input  logic       slow_hit,
  input  logic [2:0] waits,
  output logic       qx,
  output logic       ex,
  output logic       commit
);

  ck_state_t  state, state_nx;
  logic [2:0] wcnt, wcnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CK_00;
      wcnt  <= 3'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // commit is high during the last CLKX4 period of E-high, so the edge that
  // drops E is the one that updates all architectural state
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    commit   = 1'b0;
    case (state)
      CK_00: state_nx = CK_10;
      CK_10: state_nx = CK_11;
      CK_11: begin
        state_nx = CK_01;
        wcnt_nx  = slow_hit ? waits : 3'd0;
      end
      CK_01: begin
        if (mrdy && (wcnt == 3'd0)) begin
          state_nx = CK_00;
          commit   = 1'b1;
        end else if (wcnt != 3'd0) begin
          wcnt_nx = wcnt - 3'd1;
        end
      end
      default: state_nx = CK_00;
    endcase
  end

  assign {qx, ex} = state;

endmodule : mmu_clkgen
`default_nettype wire

// File: rtl/mmu_paged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmu_paged : paged 6809 MMU with task maps, write protect and slow pages   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mmu_paged
  import mmu_pkg::*;
#(
  parameter int          PAGE_BITS    = 3,
  parameter int          TASK_W       = 4,
  parameter int          FRAME_W      = 6,
  parameter logic [15:0] IO_BASE      = 16'hFE00,
  parameter logic [15:0] UART_BASE    = 16'hFE00,
  parameter logic [15:0] MMU_REG_BASE = 16'hFE10,
  parameter logic [15:0] MMU_RAM_BASE = 16'hFE20
) (
  input  logic                            CLKX4,
  input  logic                            RESET,
  input  logic [15:0]                     ADDR,
  input  logic                            RnW,
  input  logic                            BA,
  input  logic                            BS,
  input  logic [7:0]                      DATA_IN,
  output logic [7:0]                      DATA_OUT,
  output logic                            DATA_OE,
  input  logic                            MRDY,
  output logic                            QX,
  output logic                            EX,
  output logic [FRAME_W+16-PAGE_BITS-1:0] PADDR,
  output logic                            nRD,
  output logic                            nWR,
  output logic                            nCSUART,
  output logic                            nCSIO,
  output logic                            nFIRQ
);

  localparam int OFF_W  = 16 - PAGE_BITS;
  localparam int ENT_W  = FRAME_W + 2;
  localparam int NPAGES = 1 << PAGE_BITS;
  localparam int NTASKS = 1 << TASK_W;

  logic [ENT_W-1:0] table_mem [NTASKS][NPAGES];

  logic                 enmmu, fault_ie, u, fault_pend;
  logic [TASK_W-1:0]    akey, tkey, map_task;
  logic [2:0]           waits;
  logic [PAGE_BITS-1:0] fault_page, page, win_idx;
  logic [2:0]           reg_off;
  logic                 io_hit, uart_hit, reg_hit, ram_hit, vector_fetch;
  logic [ENT_W-1:0]     map_entry, win_entry, wr_entry;
  logic [FRAME_W-1:0]   frame;
  logic                 wp, slow, wp_block, commit;

  assign page         = ADDR[15:OFF_W];
  assign win_idx      = ADDR[PAGE_BITS-1:0];
  assign reg_off      = ADDR[2:0];
  assign io_hit       = (ADDR[15:8] == IO_BASE[15:8]);
  assign uart_hit     = (ADDR[15:4] == UART_BASE[15:4]);
  assign reg_hit      = (ADDR[15:3] == MMU_REG_BASE[15:3]);
  assign ram_hit      = (ADDR[15:PAGE_BITS] == MMU_RAM_BASE[15:PAGE_BITS]);
  assign vector_fetch = !BA && BS && RnW;

  // Vector fetches always run from the supervisor map even before U drops
  assign map_task  = (u && !vector_fetch) ? tkey : '0;
  assign map_entry = table_mem[map_task][page];
  assign win_entry = table_mem[akey][win_idx];
  assign wr_entry  = {DATA_IN[ENTRY_WP_BIT], DATA_IN[ENTRY_SLOW_BIT], DATA_IN[FRAME_W-1:0]};

  always_comb begin
    frame = FRAME_W'(page);
    wp    = 1'b0;
    slow  = 1'b0;
    if (enmmu && !io_hit) begin
      frame = map_entry[FRAME_W-1:0];
      slow  = map_entry[FRAME_W];
      wp    = map_entry[FRAME_W+1];
    end
  end

  assign PADDR    = {frame, ADDR[OFF_W-1:0]};
  assign wp_block = enmmu && !RnW && wp;

  assign nRD     = !(EX && RnW);
  assign nWR     = !(EX && !RnW && !wp_block);
  assign nCSUART = !(EX && uart_hit);
  assign nCSIO   = !(EX && io_hit && !uart_hit && !reg_hit && !ram_hit);
  assign nFIRQ   = !(fault_pend && fault_ie);
  assign DATA_OE = EX && RnW && (reg_hit || ram_hit);

  always_comb begin
    DATA_OUT = 8'h00;
    if (reg_hit) begin
      case (reg_off)
        REG_CTRL: begin
          DATA_OUT[CTRL_ENMMU] = enmmu;
          DATA_OUT[CTRL_FIE]   = fault_ie;
          DATA_OUT[CTRL_NU]    = !u;
        end
        REG_AKEY:  DATA_OUT[TASK_W-1:0] = akey;
        REG_TKEY:  DATA_OUT[TASK_W-1:0] = tkey;
        REG_RTI:   DATA_OUT = RTI_OPCODE;
        REG_WAITS: DATA_OUT[2:0] = waits;
        REG_FSTAT: begin
          DATA_OUT[7]              = fault_pend;
          DATA_OUT[6 -: PAGE_BITS] = fault_page;
        end
        default:   DATA_OUT = 8'h00;
      endcase
    end else if (ram_hit) begin
      DATA_OUT[ENTRY_WP_BIT]   = win_entry[FRAME_W+1];
      DATA_OUT[ENTRY_SLOW_BIT] = win_entry[FRAME_W];
      DATA_OUT[FRAME_W-1:0]    = win_entry[FRAME_W-1:0];
    end
  end

  mmu_clkgen u_clkgen (
    .clk      (CLKX4),
    .rst      (RESET),
    .mrdy     (MRDY),
    .slow_hit (slow),
    .waits    (waits),
    .qx       (QX),
    .ex       (EX),
    .commit   (commit)
  );

  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      enmmu      <= 1'b0;
      fault_ie   <= 1'b0;
      u          <= 1'b0;
      akey       <= '0;
      tkey       <= '0;
      waits      <= 3'd0;
      fault_pend <= 1'b0;
      fault_page <= '0;
    end else if (commit) begin
      if (!RnW && reg_hit) begin
        case (reg_off)
          REG_CTRL: begin
            enmmu    <= DATA_IN[CTRL_ENMMU];
            fault_ie <= DATA_IN[CTRL_FIE];
          end
          REG_AKEY:  akey  <= DATA_IN[TASK_W-1:0];
          REG_TKEY:  tkey  <= DATA_IN[TASK_W-1:0];
          REG_WAITS: waits <= DATA_IN[2:0];
          default:   ;
        endcase
      end
      if (vector_fetch)
        u <= 1'b0;
      else if (RnW && reg_hit && (reg_off == REG_RTI))
        u <= 1'b1;
      // A fresh fault outranks the clear-on-read of FSTAT
      if (wp_block) begin
        fault_pend <= 1'b1;
        fault_page <= page;
      end else if (RnW && reg_hit && (reg_off == REG_FSTAT)) begin
        fault_pend <= 1'b0;
        fault_page <= '0;
      end
    end
  end

  always_ff @(posedge CLKX4) begin
    if (commit && !RnW && ram_hit)
      table_mem[akey][win_idx] <= wr_entry;
  end

endmodule : mmu_paged
`default_nettype wire
